glitch_sequencer: RTL and testbench
===================================

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 Parameter CNT_W SHALL default to 32: width of the delay, width and gap counters.
REQ-002 Parameter NP_W SHALL default to 4: width of the pulse-count field.
REQ-003 Parameter GLITCH_POL SHALL default to 1: active level of glitch.
REQ-004 clk  in  1  single system clock (12 MHz oscillator domain); all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 locked  in  1  PLL lock status; low forces IDLE.
REQ-007 arm  in  1  one-cycle request to latch configuration and await a trigger.
REQ-008 abort  in  1  one-cycle request to return to IDLE.
REQ-009 trigger  in  1  asynchronous external trigger; the rising edge is significant.
REQ-010 delay_cnt  in  CNT_W  cycles from trigger edge to first glitch.
REQ-011 width_cnt  in  CNT_W  glitch width in cycles.
REQ-012 gap_cnt  in  CNT_W  inactive cycles between pulses.
REQ-013 pulse_num  in  NP_W  pulses per shot.
REQ-014 glitch  out  1  glitch output.
REQ-015 armed, delay_indicator, done_indicator, locked_indicator  out  1 each  status outputs.

Function
REQ-016 States SHALL be IDLE, ARMED, DELAY, PULSE, GAP and DONE.
REQ-017 trigger SHALL pass a 2-FF synchroniser; edge = sync high AND previous sync low.
REQ-018 IDLE->ARMED SHALL occur on arm with locked high, latching all four config inputs in the same cycle.
REQ-019 arm outside IDLE and DONE SHALL be ignored; arm in DONE SHALL re-latch config and go to ARMED.
REQ-020 ARMED->DELAY SHALL occur on the cycle an edge is detected; edges in any other state SHALL be ignored.
REQ-021 glitch SHALL assert exactly delay_cnt+1 cycles after the edge-detect cycle (delay_cnt=0 gives the next cycle).
REQ-022 Each pulse SHALL hold glitch active for max(width_cnt,1) cycles.
REQ-023 Between pulses, GAP SHALL hold glitch inactive for max(gap_cnt,1) cycles.
REQ-024 Pulses per shot SHALL be max(pulse_num,1); after the last pulse, go to DONE.
REQ-025 glitch SHALL be a registered output, active only in PULSE.
REQ-026 armed SHALL be high in ARMED, delay_indicator in DELAY, and done_indicator in DONE.
REQ-027 done_indicator SHALL hold until arm or abort.
REQ-028 locked_indicator SHALL be locked registered once.
REQ-029 abort, or locked low, SHALL force IDLE on the next edge from any state, with glitch inactive that cycle; abort has priority over arm.
REQ-030 Counters SHALL be CNT_W-bit down-counters with no wrap; a config input changed after latching SHALL have no effect until the next arm.

Reset
REQ-031 rst SHALL force, asynchronously: IDLE, glitch = ~GLITCH_POL, all other outputs 0, counters and synchroniser 0.
REQ-032 Release of rst SHALL not create a trigger edge even if trigger is already high.

Configuration
REQ-033 Macro GLITCH_SEQ_AUTO_REARM_EN: when defined, DONE SHALL go to ARMED after one cycle, reusing the latched config, and output shot_count (16 bit, saturating) SHALL increment per completed shot.
REQ-034 When GLITCH_SEQ_AUTO_REARM_EN is undefined, shot_count and its logic SHALL be absent and DONE SHALL hold.

Structure
REQ-035 Package glitch_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-036 Sub-module glitch_sync_edge SHALL implement the 2-FF synchroniser and rising-edge detect.

Verification
REQ-037 arm with delay=10, width=5, pulses=1, then trigger edge -> glitch high exactly 11..15 cycles after edge detect, then done_indicator=1.
REQ-038 pulses=3, width=2, gap=4 -> glitch pattern 2 on, 4 off, 2 on, 4 off, 2 on, then DONE.
REQ-039 delay=0, width=0, gap=0, pulses=0 -> a single 1-cycle glitch in the cycle after edge detect.
REQ-040 abort mid-PULSE -> glitch inactive on the next cycle, state IDLE; trigger ignored until re-arm.
REQ-041 locked low during DELAY -> IDLE, no glitch; arm ignored while locked=0.
REQ-042 With GLITCH_SEQ_AUTO_REARM_EN defined: three edges -> three identical shots and shot_count=3.

Source files
------------

// File: rtl/glitch_seq_pkg.sv
// rtl/glitch_seq_pkg.sv - shared state encoding and default parameters for the glitch sequencer
package glitch_seq_pkg;

    localparam int DEF_CNT_W      = 32;
    localparam int DEF_NP_W       = 4;
    localparam bit DEF_GLITCH_POL = 1'b1;
    localparam int SHOT_W         = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

endpackage

// File: rtl/glitch_sync_edge.sv
// rtl/glitch_sync_edge.sv - 2-FF synchroniser with rising-edge detect for the external trigger
module glitch_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_edge
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [2:0] r_fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_fill <= 3'b000;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fill <= {r_fill[1:0], 1'b1};
        end
    end

    // Edges are masked until r_prev holds a real sample, so a trigger already high at reset release is not an edge.
    assign o_edge = r_sync & ~r_prev & r_fill[2];

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - armed, triggered multi-pulse glitch generator
// GLITCH_SEQ_AUTO_REARM_EN: DONE re-arms after one cycle and shot_count tracks completed shots.
module glitch_sequencer
    import glitch_seq_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int NP_W       = DEF_NP_W,
    parameter bit GLITCH_POL = DEF_GLITCH_POL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [CNT_W-1:0] delay_cnt,
    input  logic [CNT_W-1:0] width_cnt,
    input  logic [CNT_W-1:0] gap_cnt,
    input  logic [NP_W-1:0]  pulse_num,
`ifdef GLITCH_SEQ_AUTO_REARM_EN
    output logic [SHOT_W-1:0] shot_count,
`endif
    output logic             glitch,
    output logic             armed,
    output logic             delay_indicator,
    output logic             done_indicator,
    output logic             locked_indicator
);

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NP_W-1:0]  P_ONE = {{(NP_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_gap;
    logic [NP_W-1:0]  r_pulses;
    logic [NP_W-1:0]  r_left;
    logic             r_glitch;
    logic             r_armed;
    logic             r_delay_ind;
    logic             r_done_ind;
    logic             r_locked;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
    logic [SHOT_W-1:0] r_shots;
`endif

    logic             w_edge;
    logic             w_latch;
    logic [CNT_W-1:0] w_width1;
    logic [CNT_W-1:0] w_gap1;
    logic [NP_W-1:0]  w_pulses1;

    glitch_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (trigger),
        .o_edge  (w_edge)
    );

    assign w_latch   = arm && locked && !abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_width1  = (r_width == '0) ? C_ONE : r_width;
    assign w_gap1    = (r_gap == '0) ? C_ONE : r_gap;
    assign w_pulses1 = (r_pulses == '0) ? P_ONE : r_pulses;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_delay  <= '0;
            r_width  <= '0;
            r_gap    <= '0;
            r_pulses <= '0;
        end else if (w_latch) begin
            r_delay  <= delay_cnt;
            r_width  <= width_cnt;
            r_gap    <= gap_cnt;
            r_pulses <= pulse_num;
        end
    end

    // Outputs default inactive each cycle; each transition re-asserts the flag of the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_left      <= '0;
            r_glitch    <= ~GLITCH_POL;
            r_armed     <= 1'b0;
            r_delay_ind <= 1'b0;
            r_done_ind  <= 1'b0;
            r_locked    <= 1'b0;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
            r_shots     <= '0;
`endif
        end else begin
            r_locked    <= locked;
            r_glitch    <= ~GLITCH_POL;
            r_armed     <= 1'b0;
            r_delay_ind <= 1'b0;
            r_done_ind  <= 1'b0;
            if (abort || !locked) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (arm) begin
                            r_state <= S_ARMED;
                            r_armed <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (w_edge) begin
                            r_left <= w_pulses1;
                            if (r_delay == '0) begin
                                r_state  <= S_PULSE;
                                r_cnt    <= w_width1;
                                r_glitch <= GLITCH_POL;
                            end else begin
                                r_state     <= S_DELAY;
                                r_cnt       <= r_delay;
                                r_delay_ind <= 1'b1;
                            end
                        end else begin
                            r_armed <= 1'b1;
                        end
                    end
                    S_DELAY: begin
                        if (r_cnt == C_ONE) begin
                            r_state  <= S_PULSE;
                            r_cnt    <= w_width1;
                            r_glitch <= GLITCH_POL;
                        end else begin
                            r_cnt       <= r_cnt - C_ONE;
                            r_delay_ind <= 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (r_cnt != C_ONE) begin
                            r_cnt    <= r_cnt - C_ONE;
                            r_glitch <= GLITCH_POL;
                        end else if (r_left == P_ONE) begin
                            r_state    <= S_DONE;
                            r_done_ind <= 1'b1;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
                            if (r_shots != {SHOT_W{1'b1}}) r_shots <= r_shots + 1'b1;
`endif
                        end else begin
                            r_state <= S_GAP;
                            r_cnt   <= w_gap1;
                            r_left  <= r_left - P_ONE;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == C_ONE) begin
                            r_state  <= S_PULSE;
                            r_cnt    <= w_width1;
                            r_glitch <= GLITCH_POL;
                        end else begin
                            r_cnt <= r_cnt - C_ONE;
                        end
                    end
                    S_DONE: begin
`ifdef GLITCH_SEQ_AUTO_REARM_EN
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
`else
                        if (arm) begin
                            r_state <= S_ARMED;
                            r_armed <= 1'b1;
                        end else begin
                            r_done_ind <= 1'b1;
                        end
`endif
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign glitch           = r_glitch;
    assign armed            = r_armed;
    assign delay_indicator  = r_delay_ind;
    assign done_indicator   = r_done_ind;
    assign locked_indicator = r_locked;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
    assign shot_count       = r_shots;
`endif

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - directed self-checking bench for glitch_sequencer (default build)
module tb_glitch_sequencer;

    localparam int CW = 32;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          locked;
    logic          arm;
    logic          abort;
    logic          trigger;
    logic [CW-1:0] delay_cnt;
    logic [CW-1:0] width_cnt;
    logic [CW-1:0] gap_cnt;
    logic [NW-1:0] pulse_num;
    logic          glitch;
    logic          armed;
    logic          delay_indicator;
    logic          done_indicator;
    logic          locked_indicator;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
    logic [15:0]   shot_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [63:0] cap_g;
    logic [63:0] cap_d;
    logic [63:0] cap_done;
    logic        acc;

    always #5 clk = ~clk;

    glitch_sequencer #(.CNT_W(CW), .NP_W(NW), .GLITCH_POL(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .locked           (locked),
        .arm              (arm),
        .abort            (abort),
        .trigger          (trigger),
        .delay_cnt        (delay_cnt),
        .width_cnt        (width_cnt),
        .gap_cnt          (gap_cnt),
        .pulse_num        (pulse_num),
`ifdef GLITCH_SEQ_AUTO_REARM_EN
        .shot_count       (shot_count),
`endif
        .glitch           (glitch),
        .armed            (armed),
        .delay_indicator  (delay_indicator),
        .done_indicator   (done_indicator),
        .locked_indicator (locked_indicator)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_arm(input int d, input int w, input int g, input int p);
        delay_cnt = CW'(d);
        width_cnt = CW'(w);
        gap_cnt   = CW'(g);
        pulse_num = NW'(p);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Raises trigger at a falling edge; bit i of each capture is the value seen i falling edges later.
    task automatic shoot(input int n);
        cap_g = '0;
        cap_d = '0;
        cap_done = '0;
        trigger = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            cap_g[i]    = glitch;
            cap_d[i]    = delay_indicator;
            cap_done[i] = done_indicator;
        end
    endtask

    initial begin
        rst = 1'b1; locked = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b1;
        delay_cnt = '0; width_cnt = '0; gap_cnt = '0; pulse_num = '0;
        idle(2);
        check("rst_glitch", 64'(glitch), 64'd0);
        check("rst_armed", 64'(armed), 64'd0);
        check("rst_delay", 64'(delay_indicator), 64'd0);
        check("rst_done", 64'(done_indicator), 64'd0);
        check("rst_locked", 64'(locked_indicator), 64'd0);

        // Trigger high across reset release must not start a shot.
        delay_cnt = CW'(5); width_cnt = CW'(1); pulse_num = NW'(1);
        rst = 1'b0; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("rel_armed", 64'(armed), 64'd1);
        idle(3);
        check("rel_no_edge_delay", 64'(delay_indicator), 64'd0);
        check("rel_still_armed", 64'(armed), 64'd1);
        check("locked_ind", 64'(locked_indicator), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_armed", 64'(armed), 64'd0);
        trigger = 1'b0;
        idle(3);

        // delay 10, width 5, single pulse; width input changed after latching.
        do_arm(10, 5, 3, 1);
        width_cnt = CW'(1);
        check("s1_armed", 64'(armed), 64'd1);
        shoot(25);
        check("s1_glitch", cap_g, span(13, 17));
        check("s1_delay", cap_d, span(3, 12));
        check("s1_done", cap_done, span(18, 25));
        check("s1_armed_low", 64'(armed), 64'd0);
        trigger = 1'b0;
        idle(3);

        // Re-arm from DONE: 3 pulses, width 2, gap 4, delay 1.
        do_arm(1, 2, 4, 3);
        check("s2_done_cleared", 64'(done_indicator), 64'd0);
        check("s2_armed", 64'(armed), 64'd1);
        shoot(24);
        check("s2_glitch", cap_g, span(4, 5) | span(10, 11) | span(16, 17));
        check("s2_delay", cap_d, span(3, 3));
        check("s2_done", cap_done, span(18, 24));
        trigger = 1'b0;
        idle(3);

        // All-zero config: one 1-cycle pulse right after edge detect.
        do_arm(0, 0, 0, 0);
        shoot(8);
        check("s3_glitch", cap_g, span(3, 3));
        check("s3_delay", cap_d, 64'd0);
        check("s3_done", cap_done, span(4, 8));
        trigger = 1'b0;
        idle(3);
        shoot(6);
        check("done_edge_ignored", cap_g, 64'd0);
        check("done_holds", 64'(done_indicator), 64'd1);

        arm = 1'b1; abort = 1'b1;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        check("prio_armed", 64'(armed), 64'd0);
        check("prio_done", 64'(done_indicator), 64'd0);
        trigger = 1'b0;
        idle(3);

        // Abort in the middle of a pulse.
        do_arm(2, 8, 0, 1);
        shoot(7);
        check("s4_glitch_before", cap_g, span(5, 7));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s4_glitch_off", 64'(glitch), 64'd0);
        check("s4_armed", 64'(armed), 64'd0);
        check("s4_done", 64'(done_indicator), 64'd0);
        idle(2);
        check("s4_glitch_stays_off", 64'(glitch), 64'd0);
        trigger = 1'b0;
        idle(3);
        shoot(12);
        check("s4_trig_ignored_g", cap_g, 64'd0);
        check("s4_trig_ignored_d", cap_d, 64'd0);
        trigger = 1'b0;
        idle(3);

        // Lock loss during DELAY.
        do_arm(20, 3, 0, 1);
        shoot(5);
        check("s5_delay", cap_d, span(3, 5));
        locked = 1'b0;
        @(negedge clk);
        check("s5_delay_off", 64'(delay_indicator), 64'd0);
        check("s5_locked_ind", 64'(locked_indicator), 64'd0);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("s5_arm_ignored", 64'(armed), 64'd0);
        acc = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            acc = acc | glitch;
        end
        check("s5_no_glitch", 64'(acc), 64'd0);
        locked = 1'b1;
        idle(2);
        check("s5_relock_idle", 64'(armed), 64'd0);
        check("s5_relock_ind", 64'(locked_indicator), 64'd1);
        do_arm(0, 0, 0, 0);
        check("s5_rearm", 64'(armed), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
